// File: rtl/bsg_async_ptr_gray_multi_inc_pkg.sv
// Shared helpers for the multi-increment Gray pointer and its consumer side.
// Functions work on 32-bit values; callers size-cast to their pointer width.
package bsg_async_ptr_gray_multi_inc_pkg;

    function automatic int inc_width(input int max_inc);
        return $clog2(max_inc + 1);
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/bsg_gray_step_reg.sv
// Published pointer that advances one step per enable; Gray comes straight
// from a flop fed by the lookahead, so the crossing sees no adder glitches.
module bsg_gray_step_reg
    import bsg_async_ptr_gray_multi_inc_pkg::*;
#(
    parameter int lg_size_p = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 step_i,
    output logic [lg_size_p-1:0] ptr_binary_r_o,
    output logic [lg_size_p-1:0] ptr_gray_r_o
);

    logic [lg_size_p-1:0] bin_r;
    logic [lg_size_p-1:0] look_r;
    logic [lg_size_p-1:0] gray_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bin_r  <= '0;
            look_r <= lg_size_p'(1);
            gray_r <= '0;
        end else if (step_i) begin
            bin_r  <= look_r;
            gray_r <= lg_size_p'(bin2gray(32'(look_r)));
            look_r <= look_r + lg_size_p'(1);
        end
    end

    assign ptr_binary_r_o = bin_r;
    assign ptr_gray_r_o   = gray_r;

endmodule

// File: rtl/bsg_async_ptr_gray_multi_inc.sv
// Write-side async FIFO pointer: binary jumps by the full increment, the
// published Gray pointer trails it one step per clock.
module bsg_async_ptr_gray_multi_inc
    import bsg_async_ptr_gray_multi_inc_pkg::*;
#(
    parameter int lg_size_p = 8,
    parameter int max_inc_p = 4,
    localparam int inc_width_lp = inc_width(max_inc_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [inc_width_lp-1:0] inc_i,
    output logic                    ready_o,
    output logic [lg_size_p-1:0]    ptr_binary_r_o,
    output logic [lg_size_p-1:0]    ptr_gray_r_o,
    output logic [lg_size_p-1:0]    pending_r_o,
    output logic                    caught_up_o,
    output logic                    error_r_o
);

    localparam logic [lg_size_p-1:0] room_lp =
        lg_size_p'((64'd1 << lg_size_p) - 64'd1 - 64'(max_inc_p));
    localparam logic [inc_width_lp-1:0] max_inc_lp = inc_width_lp'(max_inc_p);

    logic [lg_size_p-1:0] ptr_r;
    logic [lg_size_p-1:0] pend_r;
    logic [lg_size_p-1:0] pend_n;
    logic [lg_size_p-1:0] inc_acc;
    logic [lg_size_p-1:0] pub_bin;
    logic                 legal;
    logic                 accept;
    logic                 step;
    logic                 err_r;

    assign ready_o = (pend_r <= room_lp);
    assign legal   = (inc_i != '0) && (inc_i <= max_inc_lp);
    assign accept  = ready_o && legal;
    assign step    = (pend_r != '0);
    assign inc_acc = accept ? lg_size_p'(inc_i) : '0;
    assign pend_n  = pend_r + inc_acc - lg_size_p'(step);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_r  <= '0;
            pend_r <= '0;
            err_r  <= 1'b0;
        end else begin
            ptr_r  <= ptr_r + inc_acc;
            pend_r <= pend_n;
            if ((inc_i != '0) && !accept) begin
                err_r <= 1'b1;
            end
        end
    end

    bsg_gray_step_reg #(
        .lg_size_p(lg_size_p)
    ) u_step (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .step_i        (step),
        .ptr_binary_r_o(pub_bin),
        .ptr_gray_r_o  (ptr_gray_r_o)
    );

    // published + pending always accounts for every accepted entry
    assert property (@(posedge clk_i) disable iff (reset_i)
        (pub_bin + pend_r) == ptr_r);

    assign ptr_binary_r_o = ptr_r;
    assign pending_r_o    = pend_r;
    assign caught_up_o    = (pend_r == '0);
    assign error_r_o      = err_r;

endmodule

// File: tb/tb_bsg_async_ptr_gray_multi_inc.sv
// Directed bench with a reference model feeding a scoreboard queue.
module tb_bsg_async_ptr_gray_multi_inc;

    typedef struct packed {
        logic [7:0] bin;
        logic [7:0] gray;
        logic [7:0] pend;
        logic       err;
        logic       rdy;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic [2:0] inc_i = '0;
    logic       ready_o;
    logic [7:0] ptr_binary_r_o;
    logic [7:0] ptr_gray_r_o;
    logic [7:0] pending_r_o;
    logic       caught_up_o;
    logic       error_r_o;

    bsg_async_ptr_gray_multi_inc #(
        .lg_size_p(8),
        .max_inc_p(4)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .inc_i         (inc_i),
        .ready_o       (ready_o),
        .ptr_binary_r_o(ptr_binary_r_o),
        .ptr_gray_r_o  (ptr_gray_r_o),
        .pending_r_o   (pending_r_o),
        .caught_up_o   (caught_up_o),
        .error_r_o     (error_r_o)
    );

    always #5 clk = ~clk;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    exp_t sb[$];
    int   m_bin = 0;
    int   m_pub = 0;
    int   m_pend = 0;
    bit   m_err = 1'b0;
    logic [7:0] prev_gray = '0;
    bit   saw_wrap = 1'b0;
    bit   saw_rej = 1'b0;

    function automatic logic [7:0] gray_of(input int v);
        logic [7:0] b;
        logic [7:0] g;
        b = 8'(v);
        for (int i = 0; i < 8; i++) begin
            g[i] = (i == 7) ? b[i] : (b[i] ^ b[i+1]);
        end
        return g;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_edge(input bit rst, input int inc);
        exp_t e;
        bit   acc;
        if (rst) begin
            m_bin = 0; m_pub = 0; m_pend = 0; m_err = 1'b0;
        end else begin
            acc = (m_pend <= 251) && (inc >= 1) && (inc <= 4);
            if (inc != 0 && !acc) begin
                m_err = 1'b1;
                saw_rej = 1'b1;
            end
            if (m_pend != 0) begin
                m_pub = (m_pub + 1) % 256;
                m_pend = m_pend - 1;
            end
            if (acc) begin
                m_bin = (m_bin + inc) % 256;
                m_pend = m_pend + inc;
            end
        end
        e.bin = 8'(m_bin);
        e.gray = gray_of(m_pub);
        e.pend = 8'(m_pend);
        e.err = m_err;
        e.rdy = (m_pend <= 251);
        sb.push_back(e);
    endtask

    task automatic cyc(input bit rst, input int inc);
        exp_t e;
        reset_i = rst;
        inc_i = 3'(inc);
        model_edge(rst, inc);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("bin", int'(ptr_binary_r_o), int'(e.bin));
        check("gray", int'(ptr_gray_r_o), int'(e.gray));
        check("pend", int'(pending_r_o), int'(e.pend));
        check("err", int'(error_r_o), int'(e.err));
        check("ready", int'(ready_o), int'(e.rdy));
        check("caught_up", int'(caught_up_o), int'(e.pend == 0));
        if (!rst) begin
            check("gray_1bit", int'($countones(ptr_gray_r_o ^ prev_gray) <= 1), 1);
            if (prev_gray == 8'h80 && ptr_gray_r_o == 8'h00) saw_wrap = 1'b1;
        end
        prev_gray = ptr_gray_r_o;
        reset_i = 1'b0;
        inc_i = '0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (!caught_up_o && n < budget) begin
            cyc(1'b0, 0);
            n++;
        end
        check("drain_done", int'(caught_up_o), 1);
    endtask

    initial begin
        #2;
        cyc(1'b1, 0);
        cyc(1'b0, 0);
        check("rst_bin", int'(ptr_binary_r_o), 0);
        check("rst_ready", int'(ready_o), 1);

        cyc(1'b0, 3);
        check("inc3_bin", int'(ptr_binary_r_o), 3);
        cyc(1'b0, 0);
        check("g1", int'(ptr_gray_r_o), 'h01);
        cyc(1'b0, 0);
        check("g2", int'(ptr_gray_r_o), 'h03);
        cyc(1'b0, 0);
        check("g3", int'(ptr_gray_r_o), 'h02);
        check("p3", int'(pending_r_o), 0);

        cyc(1'b1, 0);
        for (int i = 0; i < 100; i++) cyc(1'b0, 4);
        check("flood_rejected", int'(saw_rej), 1);
        check("flood_err", int'(error_r_o), 1);
        drain(400);
        check("settle_gray", int'(ptr_gray_r_o), int'(gray_of(int'(ptr_binary_r_o))));

        cyc(1'b1, 0);
        for (int i = 0; i < 63; i++) cyc(1'b0, 4);
        check("pre_wrap_bin", int'(ptr_binary_r_o), 252);
        cyc(1'b0, 4);
        check("wrap_bin", int'(ptr_binary_r_o), 0);
        drain(400);
        check("gray_wrap_seen", int'(saw_wrap), 1);

        cyc(1'b1, 0);
        cyc(1'b0, 5);
        check("inc5_ignored", int'(ptr_binary_r_o), 0);
        cyc(1'b0, 7);
        cyc(1'b0, 0);
        cyc(1'b0, 0);
        check("err_sticky", int'(error_r_o), 1);
        cyc(1'b1, 0);
        check("err_cleared", int'(error_r_o), 0);

        cyc(1'b0, 4);
        cyc(1'b0, 4);
        cyc(1'b0, 4);
        check("pend10", int'(pending_r_o), 10);
        cyc(1'b1, 0);
        check("mid_rst_gray", int'(ptr_gray_r_o), 0);
        check("mid_rst_pend", int'(pending_r_o), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
